burst_tx_pacer: RTL and testbench

Parametrised burst fetch and paced-transmit buffer between the SDRAM read-side FIFO and the UART transmitter. It pulls fixed-size bursts out of the upstream FIFO into an internal circular buffer. It then releases one word per UART frame slot at a runtime-programmable baud rate, honouring transmitter back-pressure. It replaces the fixed 8-bit / 9600-baud reader and adds prefetch overlap, configurable frame length, and error reporting.

---
 rtl/burst_tx_pacer.sv | 192 +++++++++++++++++++
 tb/tb_burst_tx_pacer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_tx_pacer.sv
// burst_tx_pacer
//   Pulls fixed-size bursts from the upstream SDRAM read FIFO into a small
//   circular buffer. Releases one word per UART frame slot, where the slot
//   length is baud_div x frame_bits clocks. The fetch engine and the drain
//   engine run concurrently, so a new burst can be prefetched while earlier
//   words are still being paced out.
//
// Ports
//   sys_clk       system clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   burst_num     words per burst, sampled when a fetch starts
//   baud_div      clocks per bit period (values below 2 behave as 2)
//   frame_bits    bit periods per frame (0 behaves as 1)
//   src_fifo_num  upstream FIFO fill level
//   src_rd_data   upstream read data, valid one cycle after src_rd_en
//   src_rd_en     upstream read strobe
//   tx_ready      UART transmitter can accept a word
//   tx_data       word for the UART, held until the next pop
//   tx_flag       one-cycle strobe marking a new tx_data
//   busy          fetch in progress or buffer not empty
//   cfg_err       one-cycle pulse when burst_num exceeds the buffer depth
module burst_tx_pacer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [ADDR_W:0]   burst_num,
  input  logic [CNT_W-1:0]  baud_div,
  input  logic [3:0]        frame_bits,
  input  logic [ADDR_W:0]   src_fifo_num,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              src_rd_en,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_flag,
  output logic              busy,
  output logic              cfg_err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {F_IDLE, F_READ, F_LAND} fstate_t;

  // Bit period never shorter than two clocks.
  function automatic logic [CNT_W-1:0] eff_baud_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // A frame is at least one bit period long.
  function automatic logic [3:0] eff_frame_bits(input logic [3:0] f);
    return (f == 4'd0) ? 4'd1 : f;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  fstate_t         fstate;
  logic [ADDR_W:0] burst_lat;
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] level;
  logic [ADDR_W:0] free_sp;
  logic            wr_vld_p1;
  logic            cfg_bad;
  logic            cfg_bad_q;
  logic            start_ok;

  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] div_lat;
  logic [3:0]       bit_cnt;
  logic [3:0]       frame_lat;
  logic             slot_exp;
  logic             slot_end;
  logic             avail;
  logic             pop;
  logic [DATA_W-1:0] rd_word;

  // Pointers carry a wrap bit, so the plain difference is the fill level.
  assign level   = wr_ptr - rd_ptr;
  assign free_sp = DEPTH_V - level;

  assign start_ok = (fstate == F_IDLE) && (burst_num != '0) && (burst_num <= DEPTH_V) &&
                    (src_fifo_num >= burst_num) && (free_sp >= burst_num);
  assign cfg_bad  = (fstate == F_IDLE) && (burst_num > DEPTH_V);

  assign busy = (fstate != F_IDLE) || (level != '0);

  // Fetch engine: issue burst_lat back-to-back reads, then one landing cycle
  // for the final word that arrives a cycle behind its strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fstate    <= F_IDLE;
      src_rd_en <= 1'b0;
      burst_lat <= '0;
      rd_cnt    <= '0;
      wr_vld_p1 <= 1'b0;
      wr_ptr    <= '0;
      cfg_bad_q <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_bad_q <= cfg_bad;
      cfg_err   <= cfg_bad && !cfg_bad_q;
      // ---- stage p1: read strobe delayed to line up with returning data
      wr_vld_p1 <= src_rd_en;
      if (wr_vld_p1) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (fstate)
        F_IDLE: begin
          if (start_ok) begin
            fstate    <= F_READ;
            burst_lat <= burst_num;
            rd_cnt    <= (ADDR_W+1)'(1);
            src_rd_en <= 1'b1;
          end
        end
        F_READ: begin
          if (rd_cnt == burst_lat) begin
            src_rd_en <= 1'b0;
            fstate    <= F_LAND;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        F_LAND: begin
          fstate <= F_IDLE;
        end
        default: begin
          fstate    <= F_IDLE;
          src_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge sys_clk) begin
    if (wr_vld_p1) begin
      mem[wr_ptr[ADDR_W-1:0]] <= src_rd_data;
    end
  end

  // A word landing this cycle counts as available, so an empty buffer can
  // forward it straight to tx_data and strobe one cycle after the write.
  assign avail   = (level != '0) || wr_vld_p1;
  assign rd_word = (level == '0) ? src_rd_data : mem[rd_ptr[ADDR_W-1:0]];

  // slot_end marks the last clock of a running slot. Popping on it keeps
  // back-to-back strobes exactly div x frame clocks apart.
  assign slot_end = !slot_exp && (baud_cnt == div_lat - 1'b1) && (bit_cnt == frame_lat - 4'd1);
  assign pop      = avail && tx_ready && (slot_exp || slot_end);

  // Drain engine: pacing timer plus registered output word.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_ptr    <= '0;
      tx_data   <= '0;
      tx_flag   <= 1'b0;
      slot_exp  <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      div_lat   <= CNT_W'(2);
      frame_lat <= 4'd1;
    end else begin
      tx_flag <= pop;
      if (pop) begin
        tx_data   <= rd_word;
        rd_ptr    <= rd_ptr + 1'b1;
        slot_exp  <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        // Pacing settings are captured only at slot start.
        div_lat   <= eff_baud_div(baud_div);
        frame_lat <= eff_frame_bits(frame_bits);
      end else if (!slot_exp) begin
        if (baud_cnt == div_lat - 1'b1) begin
          baud_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == frame_lat - 4'd1) begin
            slot_exp <= 1'b1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_tx_pacer.sv
module tb_burst_tx_pacer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              sys_clk;
  logic              sys_rst_n;
  logic [ADDR_W:0]   burst_num;
  logic [CNT_W-1:0]  baud_div;
  logic [3:0]        frame_bits;
  logic [ADDR_W:0]   src_fifo_num;
  logic [DATA_W-1:0] src_rd_data;
  logic              src_rd_en;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_flag;
  logic              busy;
  logic              cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] txd_q[$];
  int         txc_q[$];
  int         rd_cnt  = 0;
  int         rd_first = 0;
  int         cfg_cnt = 0;
  logic [7:0] src_next = 8'h00;

  burst_tx_pacer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .burst_num    (burst_num),
    .baud_div     (baud_div),
    .frame_bits   (frame_bits),
    .src_fifo_num (src_fifo_num),
    .src_rd_data  (src_rd_data),
    .src_rd_en    (src_rd_en),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_flag      (tx_flag),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc = cyc + 1;
    end
  end

  // Observer: logs strobes mid-cycle.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_flag) begin
        txd_q.push_back(tx_data);
        txc_q.push_back(cyc);
      end
      if (src_rd_en) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_cnt = rd_cnt + 1;
      end
      if (cfg_err) cfg_cnt = cfg_cnt + 1;
    end
  end

  // Upstream FIFO model: a read strobe in cycle c presents the next word in c+1.
  initial begin
    logic f;
    src_rd_data = '0;
    forever begin
      @(negedge sys_clk);
      f = src_rd_en;
      @(posedge sys_clk);
      #1;
      if (f) begin
        src_rd_data = src_next;
        src_next    = src_next + 8'd1;
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (txd_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (txd_q.size() >= n);
  endtask

  task automatic wait_rd(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rd_cnt < n && k < budget) begin
      step();
      k++;
    end
    ok = (rd_cnt >= n);
  endtask

  task automatic clear_log();
    txd_q.delete();
    txc_q.delete();
    rd_cnt  = 0;
    cfg_cnt = 0;
  endtask

  task automatic test_reset();
    sys_rst_n    = 1'b1;
    burst_num    = '0;
    baud_div     = 16'd4;
    frame_bits   = 4'd10;
    src_fifo_num = '0;
    tx_ready     = 1'b1;
    #1 sys_rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({src_rd_en, tx_flag, busy, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {src_rd_en, tx_flag, busy, cfg_err});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", tx_data);
    end
    sys_rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_burst();
    bit ok;
    clear_log();
    src_next = 8'h10; baud_div = 16'd4; frame_bits = 4'd10; tx_ready = 1'b1;
    src_fifo_num = 5'd8; burst_num = 5'd8;
    wait_rd(1, 10, ok);
    src_fifo_num = '0;
    wait_tx(8, 600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_count got %0d want 8", txd_q.size()); end
    checks++;
    if (rd_cnt !== 8) begin errors++; $display("FAIL single_rd_en got %0d want 8", rd_cnt); end
    if (ok) begin
      checks++;
      if (txc_q[0] - rd_first !== 2) begin
        errors++; $display("FAIL single_first_latency got %0d want 2", txc_q[0] - rd_first);
      end
      for (int i = 0; i < 8; i++) begin
        logic [7:0] e;
        e = 8'h10 + 8'(i);
        checks++;
        if (txd_q[i] !== e) begin errors++; $display("FAIL single_data[%0d] got %h want %h", i, txd_q[i], e); end
        if (i > 0) begin
          checks++;
          if (txc_q[i] - txc_q[i-1] !== 40) begin
            errors++; $display("FAIL single_spacing[%0d] got %0d want 40", i, txc_q[i] - txc_q[i-1]);
          end
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    burst_num = '0;
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int k;
    clear_log();
    src_next = 8'h20; tx_ready = 1'b1;
    src_fifo_num = 5'd8; burst_num = 5'd8;
    wait_rd(1, 10, ok);
    src_fifo_num = '0;
    wait_tx(3, 200, ok);
    tx_ready = 1'b0;
    repeat (100) step();
    tx_ready = 1'b1;
    k = cyc;
    wait_tx(8, 400, ok);
    repeat (60) step();
    checks++;
    if (txd_q.size() !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", txd_q.size()); end
    if (txd_q.size() >= 8) begin
      checks++;
      if (txc_q[3] !== k + 1) begin errors++; $display("FAIL bp_resume got %0d want %0d", txc_q[3], k + 1); end
      for (int i = 0; i < 8; i++) begin
        logic [7:0] e;
        e = 8'h20 + 8'(i);
        checks++;
        if (txd_q[i] !== e) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", i, txd_q[i], e); end
        if (i > 3) begin
          checks++;
          if (txc_q[i] - txc_q[i-1] !== 40) begin
            errors++; $display("FAIL bp_spacing[%0d] got %0d want 40", i, txc_q[i] - txc_q[i-1]);
          end
        end
      end
    end
    burst_num = '0;
    step();
  endtask

  task automatic test_prefetch();
    bit ok;
    clear_log();
    src_next = 8'h30; tx_ready = 1'b1;
    src_fifo_num = 5'd16; burst_num = 5'd8;
    wait_rd(16, 200, ok);
    burst_num = '0;
    src_fifo_num = '0;
    checks++;
    if (!ok || txd_q.size() >= 8) begin
      errors++; $display("FAIL prefetch_overlap got rd=%0d tx=%0d want rd=16 tx<8", rd_cnt, txd_q.size());
    end
    wait_tx(16, 900, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL prefetch_count got %0d want 16", txd_q.size()); end
    checks++;
    if (rd_cnt !== 16) begin errors++; $display("FAIL prefetch_rd_en got %0d want 16", rd_cnt); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] e;
        e = 8'h30 + 8'(i);
        checks++;
        if (txd_q[i] !== e) begin errors++; $display("FAIL prefetch_data[%0d] got %h want %h", i, txd_q[i], e); end
        if (i > 0) begin
          checks++;
          if (txc_q[i] - txc_q[i-1] !== 40) begin
            errors++; $display("FAIL prefetch_spacing[%0d] got %0d want 40", i, txc_q[i] - txc_q[i-1]);
          end
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL prefetch_busy_end got %b want 0", busy); end
  endtask

  task automatic test_cfg_err();
    clear_log();
    src_fifo_num = 5'd16; burst_num = 5'd17;
    repeat (20) step();
    checks++;
    if (cfg_cnt !== 1) begin errors++; $display("FAIL cfg_pulse got %0d want 1", cfg_cnt); end
    checks++;
    if (rd_cnt !== 0) begin errors++; $display("FAIL cfg_no_read got %0d want 0", rd_cnt); end
    burst_num = '0;
    repeat (10) step();
    checks++;
    if (cfg_cnt !== 1 || rd_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL cfg_zero_burst got err=%0d rd=%0d busy=%b want 1 0 0", cfg_cnt, rd_cnt, busy);
    end
    burst_num = 5'd17;
    repeat (10) step();
    checks++;
    if (cfg_cnt !== 2) begin errors++; $display("FAIL cfg_repulse got %0d want 2", cfg_cnt); end
    burst_num = '0;
    src_fifo_num = '0;
    step();
  endtask

  task automatic test_min_divider();
    bit ok;
    clear_log();
    src_next = 8'h50; baud_div = 16'd1; frame_bits = 4'd0; tx_ready = 1'b1;
    src_fifo_num = 5'd4; burst_num = 5'd4;
    wait_rd(1, 10, ok);
    src_fifo_num = '0;
    wait_tx(4, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mindiv_count got %0d want 4", txd_q.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] e;
        e = 8'h50 + 8'(i);
        checks++;
        if (txd_q[i] !== e) begin errors++; $display("FAIL mindiv_data[%0d] got %h want %h", i, txd_q[i], e); end
        if (i > 0) begin
          checks++;
          if (txc_q[i] - txc_q[i-1] !== 2) begin
            errors++; $display("FAIL mindiv_spacing[%0d] got %0d want 2", i, txc_q[i] - txc_q[i-1]);
          end
        end
      end
    end
    burst_num = '0; baud_div = 16'd4; frame_bits = 4'd10;
    repeat (5) step();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    clear_log();
    src_next = 8'h60; tx_ready = 1'b1;
    src_fifo_num = 5'd8; burst_num = 5'd8;
    wait_rd(4, 20, ok);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {src_rd_en, tx_flag, busy, cfg_err} !== 4'b0000) begin
      errors++; $display("FAIL midrst_ctrl got %b want 0000", {src_rd_en, tx_flag, busy, cfg_err});
    end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", tx_data); end
    src_fifo_num = '0; burst_num = '0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || src_rd_en !== 1'b0) begin
      errors++; $display("FAIL midrst_release got busy=%b rd=%b want 0 0", busy, src_rd_en);
    end
    clear_log();
    src_next = 8'h70; src_fifo_num = 5'd4; burst_num = 5'd4;
    wait_rd(1, 10, ok);
    src_fifo_num = '0;
    wait_tx(4, 300, ok);
    checks++;
    if (!ok || rd_cnt !== 4) begin
      errors++; $display("FAIL midrst_fresh got tx=%0d rd=%0d want 4 4", txd_q.size(), rd_cnt);
    end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] e;
        e = 8'h70 + 8'(i);
        checks++;
        if (txd_q[i] !== e) begin errors++; $display("FAIL midrst_data[%0d] got %h want %h", i, txd_q[i], e); end
        if (i > 0) begin
          checks++;
          if (txc_q[i] - txc_q[i-1] !== 40) begin
            errors++; $display("FAIL midrst_spacing[%0d] got %0d want 40", i, txc_q[i] - txc_q[i-1]);
          end
        end
      end
    end
    burst_num = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_prefetch();
    test_cfg_err();
    test_min_divider();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
